cp0: RTL and testbench
======================

# cp0

Coprocessor-0 register file and exception responder for the five-stage MIPS pipeline. It consumes the exception request raised at commit (mem stage) by the control unit, records exception state in Status/Cause/EPC/BadVAddr, and drives the pipeline flush and PC redirect. It also services ERET, MTC0/MFC0, the Count/Compare timer and the interrupt request fed back to the control unit.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ext_int  in  6  hardware interrupt lines, level-sensitive
- exc_valid  in  1  committing instruction raises an exception
- exc_code  in  5  ExcCode of that exception
- exc_bd  in  1  faulting instruction sits in a delay slot
- exc_pc  in  32  PC of faulting instruction
- exc_badvaddr  in  32  faulting address (AdEL/AdES)
- eret  in  1  committing ERET
- mtc0_we  in  1  committing MTC0
- cp0_waddr  in  8  {rd[4:0], sel[2:0]}
- cp0_wdata  in  32  MTC0 data
- cp0_raddr  in  8  MFC0 address
- cp0_rdata  out  32  MFC0 data, combinational; unmapped address → 0
- int_req  out  1  enabled interrupt pending, registered
- flush  out  1  flush all stages younger than mem
- redirect_pc  out  32  fetch target when flush=1
- status_exl  out  1  Status.EXL

## Operation
- Registers (rd,sel=0): BadVAddr 8, Count 9, Compare 11, Status 12, Cause 13, EPC 14.
- Reset: Status=STATUS_RST; Cause, EPC, BadVAddr, Count, Compare, tick toggle, int_req = 0. flush=0, redirect_pc=0 while rst=1.
- Exception (exc_valid): Status.EXL←1; Cause.ExcCode←exc_code; if EXL was 0: EPC←exc_bd ? exc_pc−4 : exc_pc, Cause.BD←exc_bd; if EXL was 1, EPC and BD unchanged. BadVAddr←exc_badvaddr only for codes 4 (AdEL) and 5 (AdES).
- ERET: Status.EXL←0.
- MTC0 write masks: Status only IM[15:8], EXL[1], IE[0]; Cause only IP[1:0]; EPC, BadVAddr read-only to software except EPC (fully writable); Compare write also clears Cause.TI[30].
- Cause.IP[7:2]←ext_int every cycle; IP[7] = ext_int[5] | TI.
- int_req_next = Status.IE & ~Status.EXL & |(Cause.IP & Status.IM).
- Same-cycle priority: exc_valid > eret > mtc0_we; lower-priority events suppressed.
- flush = exc_valid | eret; redirect_pc = exc_valid ? EXC_VECTOR : EPC (current, pre-update value).
- MFC0 reads return the current register value; no bypass of a same-cycle MTC0.

## Timing
- flush/redirect_pc combinational, same cycle as request; register side effects visible next cycle.
- int_req: one cycle after the contributing IP/IM/IE/EXL change.
- Count increments every second cycle (tick toggle); MTC0 Count overrides increment and resets toggle phase to 0.
- TI set the cycle after Count equals Compare (compare on post-update Count); Compare write clearing TI wins over a same-cycle match.
- Count wraps 32'hFFFF_FFFF → 0 silently.
- Reset mid-exception: rst overrides all writes that cycle.

## Configuration
- CP0_TIMER_EN defined: Count/Compare/TI implemented as above.
- Undefined: Count and Compare read 0, writes ignored, TI constant 0, IP[7]=ext_int[5]; no counter flops synthesized.

## Structure
- Shared package: CP0 register address constants, ExcCode constants (Int 0, AdEL 4, AdES 5, Sys 8, Bp 9, RI 10, Ov 12), Status/Cause bit-position constants.
- One sub-module: cp0_timer (Count, Compare, toggle, TI), instantiated only under CP0_TIMER_EN.

## Test plan
- Reset then MFC0 Status → 32'h0040_0000; Cause, EPC → 0; flush=0.
- exc_valid, code 4, pc 32'hBFC0_1004, bd=1, badvaddr 32'h1 → flush=1, redirect_pc=32'hBFC0_0380 same cycle; next cycle EPC=32'hBFC0_1000, Cause.BD=1, ExcCode=4, BadVAddr=1, EXL=1.
- Second exception (code 12) with EXL=1 → EPC unchanged, ExcCode=12, BadVAddr unchanged.
- ERET with EPC=32'hBFC0_1000 → redirect_pc=32'hBFC0_1000, EXL=0 next cycle.
- MTC0 Status=32'h0000_0401, ext_int=6'b000001 → int_req=1 two cycles later; MTC0 EXL=1 → int_req=0.
- Timer: Compare=5, Count=0 → TI set at cycle ~10, int_req with IM7/IE set; MTC0 Compare clears TI.

Source files
------------

// File: rtl/cp0_pkg.sv
// CP0 shared definitions: register addresses, ExcCodes, Status/Cause bit positions.
// Optional Count/Compare timer is selected by the CP0_TIMER_EN macro.
package cp0_pkg;

  localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
  localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
  localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

  // MFC0/MTC0 addresses are {rd[4:0], sel[2:0]}
  localparam logic [7:0] CP0_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] CP0_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] CP0_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] CP0_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] CP0_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] CP0_EPC      = {5'd14, 3'd0};

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  typedef struct packed {
    logic       bd;
    logic       ti;
    logic [7:0] ip;
    logic [4:0] exc_code;
  } cause_t;

  function automatic logic [31:0] pack_cause(input cause_t c);
    return {c.bd, c.ti, 14'b0, c.ip, 1'b0, c.exc_code, 2'b0};
  endfunction

  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_if.sv
// Pipeline <-> CP0 bundle: commit-stage requests in, MFC0 data, flush/redirect and interrupt out.
// master = pipeline control side, slave = CP0.
interface cp0_if;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic        exc_bd;
  logic [31:0] exc_pc;
  logic [31:0] exc_badvaddr;
  logic        eret;
  logic        mtc0_we;
  logic [7:0]  cp0_waddr;
  logic [31:0] cp0_wdata;
  logic [7:0]  cp0_raddr;
  logic [31:0] cp0_rdata;
  logic        int_req;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        status_exl;

  modport master (
    output exc_valid, exc_code, exc_bd, exc_pc, exc_badvaddr, eret,
           mtc0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    input  cp0_rdata, int_req, flush, redirect_pc, status_exl
  );

  modport slave (
    input  exc_valid, exc_code, exc_bd, exc_pc, exc_badvaddr, eret,
           mtc0_we, cp0_waddr, cp0_wdata, cp0_raddr,
    output cp0_rdata, int_req, flush, redirect_pc, status_exl
  );
endinterface

// File: rtl/cp0_timer.sv
// Count/Compare timer (built only with CP0_TIMER_EN): Count advances every second cycle, TI sticky.
// Writes take effect next cycle; a Compare write clears TI and beats a same-cycle match.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic        toggle;
  logic        inc;
  logic [31:0] count_nxt;

  // A software Count write restarts the half-rate phase
  always_comb begin
    inc       = toggle & ~count_we;
    count_nxt = count;
    if (count_we)
      count_nxt = wdata;
    else if (inc)
      count_nxt = count + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      toggle  <= 1'b0;
      ti      <= 1'b0;
    end else begin
      count  <= count_nxt;
      toggle <= count_we ? 1'b0 : ~toggle;
      if (compare_we) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (inc && (count_nxt == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0.sv
// CP0 register file + exception responder; flush/redirect combinational, state updates next cycle,
// int_req registered. No backpressure. Timer present only when CP0_TIMER_EN is defined.
module cp0
  import cp0_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] ext_int,
  cp0_if.slave       bus
);

  logic [31:0] status;
  logic [31:0] epc;
  logic [31:0] badvaddr;
  logic        cause_bd;
  logic [4:0]  cause_code;
  logic [1:0]  ip_sw;
  logic [5:0]  ip_hw;
  logic        int_req_q;

  logic        ti;
  logic [31:0] count;
  logic [31:0] compare;
  logic [7:0]  ip;
  cause_t      cause;

  logic        eret_go;
  logic        mtc0_go;

  assign eret_go = bus.eret & ~bus.exc_valid;
  assign mtc0_go = bus.mtc0_we & ~bus.exc_valid & ~bus.eret;

`ifdef CP0_TIMER_EN
  logic wr_count;
  logic wr_compare;

  assign wr_count   = mtc0_go && (bus.cp0_waddr == CP0_COUNT);
  assign wr_compare = mtc0_go && (bus.cp0_waddr == CP0_COMPARE);

  cp0_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .count_we   (wr_count),
    .compare_we (wr_compare),
    .wdata      (bus.cp0_wdata),
    .count      (count),
    .compare    (compare),
    .ti         (ti)
  );
`else
  assign count   = '0;
  assign compare = '0;
  assign ti      = 1'b0;
`endif

  assign ip = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};

  always_comb begin
    cause          = '0;
    cause.bd       = cause_bd;
    cause.ti       = ti;
    cause.ip       = ip;
    cause.exc_code = cause_code;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      status     <= STATUS_RST;
      epc        <= '0;
      badvaddr   <= '0;
      cause_bd   <= 1'b0;
      cause_code <= '0;
      ip_sw      <= '0;
      ip_hw      <= '0;
      int_req_q  <= 1'b0;
    end else begin
      ip_hw     <= ext_int;
      int_req_q <= status[ST_IE] & ~status[ST_EXL] & (|(ip & status[15:8]));
      if (bus.exc_valid) begin
        status[ST_EXL] <= 1'b1;
        cause_code     <= bus.exc_code;
        // Nested exceptions keep the original return point
        if (!status[ST_EXL]) begin
          epc      <= bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          cause_bd <= bus.exc_bd;
        end
        if (is_addr_exc(bus.exc_code))
          badvaddr <= bus.exc_badvaddr;
      end else if (eret_go) begin
        status[ST_EXL] <= 1'b0;
      end else if (mtc0_go) begin
        case (bus.cp0_waddr)
          CP0_STATUS: status <= (status & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
          CP0_CAUSE:  ip_sw  <= bus.cp0_wdata[9:8];
          CP0_EPC:    epc    <= bus.cp0_wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_raddr)
      CP0_BADVADDR: bus.cp0_rdata = badvaddr;
      CP0_COUNT:    bus.cp0_rdata = count;
      CP0_COMPARE:  bus.cp0_rdata = compare;
      CP0_STATUS:   bus.cp0_rdata = status;
      CP0_CAUSE:    bus.cp0_rdata = pack_cause(cause);
      CP0_EPC:      bus.cp0_rdata = epc;
      default:      bus.cp0_rdata = '0;
    endcase
  end

  assign bus.flush       = ~rst & (bus.exc_valid | bus.eret);
  assign bus.redirect_pc = rst ? 32'd0 : (bus.exc_valid ? EXC_VECTOR : epc);
  assign bus.int_req     = int_req_q;
  assign bus.status_exl  = status[ST_EXL];

endmodule

// File: tb/tb_cp0.sv
// Scoreboard bench for cp0: expectations queued as stimulus is applied, popped as outputs are sampled.
module tb_cp0;
  import cp0_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] ext_int;

  cp0_if bus ();

  cp0 dut (
    .clk     (clk),
    .rst     (rst),
    .ext_int (ext_int),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  localparam logic [7:0] OBS_FLUSH  = 8'hF0;
  localparam logic [7:0] OBS_REDIR  = 8'hF1;
  localparam logic [7:0] OBS_INTREQ = 8'hF2;
  localparam logic [7:0] OBS_EXL    = 8'hF3;

  typedef struct {
    string       nm;
    logic [7:0]  addr;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic push(input string nm, input logic [7:0] a, input logic [31:0] v);
    exp_t e;
    e.nm = nm; e.addr = a; e.v = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [7:0] a, output logic [31:0] v);
    bus.cp0_raddr = a;
    #1;
    case (a)
      OBS_FLUSH:  v = {31'b0, bus.flush};
      OBS_REDIR:  v = bus.redirect_pc;
      OBS_INTREQ: v = {31'b0, bus.int_req};
      OBS_EXL:    v = {31'b0, bus.status_exl};
      default:    v = bus.cp0_rdata;
    endcase
  endtask

  task automatic idle();
    bus.exc_valid = 0; bus.exc_code = '0; bus.exc_bd = 0; bus.exc_pc = '0;
    bus.exc_badvaddr = '0; bus.eret = 0; bus.mtc0_we = 0;
    bus.cp0_waddr = '0; bus.cp0_wdata = '0;
  endtask

  task automatic raise(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                       input logic [31:0] bva);
    bus.exc_valid = 1; bus.exc_code = code; bus.exc_pc = pc; bus.exc_bd = bd;
    bus.exc_badvaddr = bva;
  endtask

  // One MTC0, applied at the next rising edge; returns on the following falling edge
  task automatic mtc0(input logic [7:0] a, input logic [31:0] d);
    bus.mtc0_we = 1; bus.cp0_waddr = a; bus.cp0_wdata = d;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    exp_t e; logic [31:0] obs;
    idle(); ext_int = '0; rst = 1;
    raise(EXC_ADEL, 32'h100, 1'b0, 32'h55);
    push("rst_flush", OBS_FLUSH, 32'd0);
    push("rst_redirect", OBS_REDIR, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    repeat (2) @(negedge clk);
    idle(); rst = 0;
    push("reset_status", CP0_STATUS, STATUS_RST);
    push("reset_cause", CP0_CAUSE, 32'd0);
    push("reset_epc", CP0_EPC, 32'd0);
    push("reset_badvaddr", CP0_BADVADDR, 32'd0);
    push("reset_int_req", OBS_INTREQ, 32'd0);
    push("reset_flush", OBS_FLUSH, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_exception();
    exp_t e; logic [31:0] obs;
    raise(EXC_ADEL, 32'hBFC0_1004, 1'b1, 32'h1);
    push("exc_flush", OBS_FLUSH, 32'd1);
    push("exc_redirect", OBS_REDIR, 32'hBFC0_0380);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle();
    push("exc_epc", CP0_EPC, 32'hBFC0_1000);
    push("exc_cause", CP0_CAUSE, 32'h8000_0010);
    push("exc_badvaddr", CP0_BADVADDR, 32'h1);
    push("exc_status", CP0_STATUS, 32'h0040_0002);
    push("exc_exl", OBS_EXL, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_nested();
    exp_t e; logic [31:0] obs;
    raise(EXC_OV, 32'h1234_5678, 1'b0, 32'hDEAD);
    @(negedge clk); idle();
    push("nest_epc", CP0_EPC, 32'hBFC0_1000);
    push("nest_cause", CP0_CAUSE, 32'h8000_0030);
    push("nest_badvaddr", CP0_BADVADDR, 32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_eret();
    exp_t e; logic [31:0] obs;
    bus.eret = 1;
    push("eret_flush", OBS_FLUSH, 32'd1);
    push("eret_redirect", OBS_REDIR, 32'hBFC0_1000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle();
    push("eret_status", CP0_STATUS, 32'h0040_0000);
    push("eret_exl", OBS_EXL, 32'd0);
    push("eret_flush_off", OBS_FLUSH, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_interrupt();
    exp_t e; logic [31:0] obs;
    ext_int = 6'b000001;
    mtc0(CP0_STATUS, 32'h0000_0401);
    push("irq_not_yet", OBS_INTREQ, 32'd0);
    push("irq_status", CP0_STATUS, 32'h0040_0401);
    push("irq_cause_ip2", CP0_CAUSE, 32'h8000_0430);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk);
    push("irq_raised", OBS_INTREQ, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    mtc0(CP0_STATUS, 32'h0000_0403);
    push("irq_exl_lag", OBS_INTREQ, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk);
    push("irq_masked_exl", OBS_INTREQ, 32'd0);
    push("irq_exl_set", OBS_EXL, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_write_masks();
    exp_t e; logic [31:0] obs;
    mtc0(CP0_STATUS, 32'hFFFF_FFFF);
    mtc0(CP0_CAUSE, 32'hFFFF_FFFF);
    mtc0(CP0_BADVADDR, 32'h0000_1234);
    mtc0(CP0_EPC, 32'hCAFE_F00C);
    push("mask_status", CP0_STATUS, 32'h0040_FF03);
    push("mask_cause", CP0_CAUSE, 32'h8000_0730);
    push("mask_badvaddr_ro", CP0_BADVADDR, 32'h1);
    push("mask_epc", CP0_EPC, 32'hCAFE_F00C);
    push("mask_unmapped", 8'h08, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    mtc0(CP0_STATUS, 32'h0);
    mtc0(CP0_CAUSE, 32'h0);
    push("mask_status_clr", CP0_STATUS, 32'h0040_0000);
    push("mask_cause_clr", CP0_CAUSE, 32'h8000_0430);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_priority();
    exp_t e; logic [31:0] obs;
    raise(EXC_SYS, 32'h0000_0200, 1'b0, 32'h777);
    bus.eret = 1; bus.mtc0_we = 1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h5555;
    push("prio_exc_redirect", OBS_REDIR, EXC_VECTOR);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle();
    push("prio_epc", CP0_EPC, 32'h0000_0200);
    push("prio_cause", CP0_CAUSE, 32'h0000_0420);
    push("prio_status", CP0_STATUS, 32'h0040_0002);
    push("prio_badvaddr", CP0_BADVADDR, 32'h1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    bus.eret = 1; bus.mtc0_we = 1; bus.cp0_waddr = CP0_EPC; bus.cp0_wdata = 32'h7777;
    push("prio_eret_redirect", OBS_REDIR, 32'h0000_0200);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle();
    push("prio_eret_epc", CP0_EPC, 32'h0000_0200);
    push("prio_eret_status", CP0_STATUS, 32'h0040_0000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; logic [31:0] obs;
    raise(EXC_ADES, 32'h0000_0300, 1'b0, 32'h0000_0ABC);
    @(negedge clk); idle();
    bus.eret = 1;
    push("b2b_redirect", OBS_REDIR, 32'h0000_0300);
    push("b2b_cause", CP0_CAUSE, 32'h0000_0414);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle();
    push("b2b_badvaddr", CP0_BADVADDR, 32'h0000_0ABC);
    push("b2b_status", CP0_STATUS, 32'h0040_0000);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e; logic [31:0] obs;
    ext_int = '0;
    raise(EXC_ADEL, 32'h0000_0400, 1'b0, 32'h999);
    rst = 1;
    push("rstmid_flush", OBS_FLUSH, 32'd0);
    push("rstmid_redirect", OBS_REDIR, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk); idle(); rst = 0;
    push("rstmid_status", CP0_STATUS, STATUS_RST);
    push("rstmid_epc", CP0_EPC, 32'd0);
    push("rstmid_badvaddr", CP0_BADVADDR, 32'd0);
    push("rstmid_cause", CP0_CAUSE, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    exp_t e; logic [31:0] obs; logic [31:0] cause_v; int n;
    mtc0(CP0_COMPARE, 32'd5);
    mtc0(CP0_COUNT, 32'd0);
    n = 0;
    observe(CP0_CAUSE, cause_v);
    while (!cause_v[CA_TI] && n < 40) begin
      @(negedge clk); n++;
      observe(CP0_CAUSE, cause_v);
    end
    // Count reaches 5 on the tenth edge after the write; TI is set on that same edge
    push("timer_ti_latency", 8'hFE, 32'd10);
    push("timer_count", CP0_COUNT, 32'd5);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.addr == 8'hFE) obs = n; else observe(e.addr, obs);
      n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    mtc0(CP0_STATUS, 32'h0000_8001);
    @(negedge clk);
    push("timer_int_req", OBS_INTREQ, 32'd1);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    mtc0(CP0_COMPARE, 32'd100);
    push("timer_ti_clear", CP0_CAUSE, 32'd0);
    push("timer_compare", CP0_COMPARE, 32'd100);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
    @(negedge clk);
    push("timer_int_drop", OBS_INTREQ, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask
`else
  task automatic test_timer();
    exp_t e; logic [31:0] obs;
    mtc0(CP0_COUNT, 32'h55);
    mtc0(CP0_COMPARE, 32'h66);
    repeat (12) @(negedge clk);
    push("notimer_count", CP0_COUNT, 32'd0);
    push("notimer_compare", CP0_COMPARE, 32'd0);
    push("notimer_cause", CP0_CAUSE, 32'd0);
    while (sb.size() != 0) begin
      e = sb.pop_front(); observe(e.addr, obs); n_checks++;
      if (obs !== e.v) begin n_fail++; $display("FAIL %s: got %h expected %h", e.nm, obs, e.v); end
    end
  endtask
`endif

  initial begin
    bus.cp0_raddr = '0;
    idle();
    ext_int = '0;
    rst = 1;
    @(negedge clk);
    test_reset();
    test_exception();
    test_nested();
    test_eret();
    test_interrupt();
    test_write_masks();
    test_priority();
    test_back_to_back();
    test_reset_mid();
    test_timer();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
